crc_decoder: RTL and testbench
==============================

Name: crc_decoder

Overview:
- Receive-side checker for the CRC-7 link.
- Accepts the 23-bit codeword produced by the encoder stage, formatted {data[15:0], crc[6:0]}.
- Divides the codeword serially, MSB first, one bit per clock, by G(x)=x^7+x^3+1.
- Reports the recovered data, the 7-bit syndrome and an error flag, plus a one-cycle valid strobe.

Parameters:
- DATA_W, 16, payload width.
- CRC_W, 7, CRC/syndrome width.
- POLY, 7'h09, generator polynomial without the x^7 term.
- CW_W, DATA_W+CRC_W (23), codeword width. Derived; must not be overridden.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en_code  in  1  codeword-present strobe; sampled on the rising edge.
- CODE_IN  in  CW_W  codeword {data, crc}.
- DATA_OUT  out  DATA_W  recovered payload, CODE_IN[CW_W-1:CRC_W] of the checked word.
- SYN_OUT  out  CRC_W  syndrome; 0 means no detected error.
- CRC_Err  out  1  1 when SYN_OUT != 0.
- Chk_Valid  out  1  one-cycle pulse; outputs updated this cycle.
- Busy  out  1  checker is dividing; en_code is ignored while high.

Behaviour:
- Reset (synchronous, active-high, CLK edge with reset=1):
  - state=IDLE; shift register, remainder and bit counter cleared.
  - DATA_OUT=0, SYN_OUT=0, CRC_Err=0, Chk_Valid=0, Busy=0.
  - Reset has priority over all other inputs. Reset mid-SHIFT aborts the word; no Chk_Valid is produced for it.
- FSM states: IDLE, SHIFT. There is no separate DONE state.
- IDLE:
  - If en_code=1: load sh<=CODE_IN, rem<=0, cnt<=0, and go to SHIFT.
  - Busy is high from the next cycle.
  - If en_code=0: stay in IDLE.
- SHIFT, every edge:
  - b=sh[CW_W-1]; fb=rem[6]^b.
  - rem<={rem[5:0],1'b0} ^ (fb ? POLY : 0).
  - sh<={sh[CW_W-2:0],1'b0}; cnt<=cnt+1.
  - cnt is 5 bits and counts 0..22; it never wraps.
- Final SHIFT edge (cnt==CW_W-1):
  - SYN_OUT<=next rem; CRC_Err<=(next rem!=0).
  - DATA_OUT<=captured payload. The payload is held in a separate register loaded at capture.
  - Chk_Valid<=1 for exactly one cycle; state<=IDLE; Busy<=0.
- Latency: Chk_Valid goes high 23 clock edges after the capture edge.
- Busy is high for the 23 cycles between those two edges.
- Back-to-back: en_code=1 in the same cycle Chk_Valid=1 is accepted, giving a throughput of one codeword per 24 cycles.
- en_code=1 while Busy=1 is ignored. No queueing, no error flag.
- DATA_OUT, SYN_OUT and CRC_Err hold their values until the next final SHIFT edge or reset.
- Syndrome value:
  - SYN_OUT = codeword·x^7 mod G. It is zero iff the codeword is divisible by G.
  - A single-bit error at codeword bit i gives syndrome x^(i+7) mod G, which is never 0.
- CODE_IN is only sampled at the capture edge; changes during SHIFT have no effect.

Decomposition:
- Shared package crc7_pkg holds:
  - CRC7_POLY=7'h09, CRC7_DATA_W=16, CRC7_W=7, CRC7_CW_W=23;
  - state typedef {IDLE, SHIFT}.
  - The encoder stage uses the same constants, so polynomial and format stay identical.
- One combinational sub-module is natural: crc7_step (rem_in, bit_in -> rem_out), implementing one LFSR step.
- The FSM, counter, shift register and output registers live in crc_decoder.

Test Plan:
- Reset during operation:
  - Assert reset at cycle 10 of SHIFT.
  - Next cycle: Busy=0, all outputs 0, and no Chk_Valid ever appears for that word.
- Valid word:
  - CODE_IN=23'h000089 ({16'h0001,7'h09}) with en_code pulse.
  - 23 edges later: Chk_Valid=1 for one cycle, SYN_OUT=7'h00, CRC_Err=0, DATA_OUT=16'h0001.
- Single-bit error in CRC bit 0:
  - CODE_IN=23'h000088.
  - Response: SYN_OUT=7'h09, CRC_Err=1, DATA_OUT=16'h0001.
- All-zero and encoder loopback:
  - CODE_IN=23'h000000 gives SYN_OUT=0, CRC_Err=0.
  - Drive the encoder with 1000 random DATA_IN and feed its codeword in: every result has CRC_Err=0 and DATA_OUT==DATA_IN.
- Busy and back-to-back:
  - Pulse en_code at cycle 5 of SHIFT: it is ignored and the first result is unchanged.
  - Pulse en_code in the Chk_Valid cycle with 23'h000088: accepted, Busy=1 next cycle, second Chk_Valid 23 edges later with CRC_Err=1.

Source files
------------

// File: rtl/crc7_pkg.sv
// Shared constants and types for the CRC-7 link (x^7 + x^3 + 1).
// The encoder and decoder both import this package, so the polynomial and
// the {data, crc} codeword format cannot drift apart between the two stages.
package crc7_pkg;

    localparam int          CRC7_DATA_W = 16;
    localparam int          CRC7_W      = 7;
    localparam int          CRC7_CW_W   = CRC7_DATA_W + CRC7_W;  // 23
    localparam logic [6:0]  CRC7_POLY   = 7'h09;                 // x^3 + 1, x^7 implied

    typedef enum logic {
        IDLE,
        SHIFT
    } crc7_state_e;

    // One checked word as reported to the consumer.
    typedef struct packed {
        logic [CRC7_DATA_W-1:0] data;
        logic [CRC7_W-1:0]      syn;
        logic                   err;
    } crc7_result_t;

endpackage

// File: rtl/crc7_step.sv
// One serial step of the CRC-7 division (MSB-first LFSR, Galois form).
// Ports:
//   rem_in  : current remainder
//   bit_in  : next codeword bit
//   rem_out : remainder after absorbing bit_in
module crc7_step
    import crc7_pkg::*;
#(
    parameter int              CRC_W = CRC7_W,
    parameter logic [CRC_W-1:0] POLY = CRC7_POLY
) (
    input  logic [CRC_W-1:0] rem_in,
    input  logic             bit_in,
    output logic [CRC_W-1:0] rem_out
);

    logic fb;

    // Feeding the bit in at the top means the final remainder equals
    // codeword * x^CRC_W mod G, which is zero exactly when G divides it.
    assign fb      = rem_in[CRC_W-1] ^ bit_in;
    assign rem_out = {rem_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_decoder.sv
// Serial CRC-7 checker for 23-bit {data[15:0], crc[6:0]} codewords.
// A word is captured when en_code is high in IDLE, then divided one bit per
// clock, MSB first. After 23 shift edges the payload, syndrome and error
// flag are registered and Chk_Valid pulses for one cycle.
// Ports:
//   CLK       : clock, rising edge
//   reset     : synchronous active-high reset
//   en_code   : codeword-present strobe (ignored while Busy)
//   CODE_IN   : codeword {data, crc}, sampled only at capture
//   DATA_OUT  : recovered payload of the last checked word
//   SYN_OUT   : syndrome of the last checked word (0 = no detected error)
//   CRC_Err   : SYN_OUT != 0
//   Chk_Valid : one-cycle pulse when the outputs above were updated
//   Busy      : division in progress
module crc_decoder
    import crc7_pkg::*;
#(
    parameter int               DATA_W = CRC7_DATA_W,
    parameter int               CRC_W  = CRC7_W,
    parameter logic [CRC_W-1:0] POLY   = CRC7_POLY
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      en_code,
    input  logic [DATA_W+CRC_W-1:0]   CODE_IN,
    output logic [DATA_W-1:0]         DATA_OUT,
    output logic [CRC_W-1:0]          SYN_OUT,
    output logic                      CRC_Err,
    output logic                      Chk_Valid,
    output logic                      Busy
);

    localparam int CW_W  = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(CW_W);

    crc7_state_e       state, state_nxt;
    logic [CW_W-1:0]   sh;
    logic [CRC_W-1:0]  rem, rem_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_q;
    logic              last;
    logic              vld_q;
    crc7_result_t      res_q;

    assign last = (cnt == CNT_W'(CW_W - 1));

    crc7_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .rem_in  (rem),
        .bit_in  (sh[CW_W-1]),
        .rem_out (rem_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_code) state_nxt = SHIFT;
            SHIFT:   if (last)    state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state  <= IDLE;
            sh     <= '0;
            rem    <= '0;
            cnt    <= '0;
            data_q <= '0;
            res_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_code) begin
                        sh     <= CODE_IN;
                        rem    <= '0;
                        cnt    <= '0;
                        // The shift register is consumed during division, so
                        // the payload is kept aside for reporting.
                        data_q <= CODE_IN[CW_W-1:CRC_W];
                    end
                end
                SHIFT: begin
                    sh  <= {sh[CW_W-2:0], 1'b0};
                    rem <= rem_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        res_q.data <= data_q;
                        res_q.syn  <= rem_nxt;
                        res_q.err  <= |rem_nxt;
                        vld_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DATA_OUT  = res_q.data;
    assign SYN_OUT   = res_q.syn;
    assign CRC_Err   = res_q.err;
    assign Chk_Valid = vld_q;
    assign Busy      = (state == SHIFT);

endmodule

// File: tb/tb_crc_decoder.sv
module tb_crc_decoder;
    import crc7_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic        en_code;
    logic [22:0] CODE_IN;
    logic [15:0] DATA_OUT;
    logic [6:0]  SYN_OUT;
    logic        CRC_Err;
    logic        Chk_Valid;
    logic        Busy;

    crc_decoder dut (
        .CLK       (CLK),
        .reset     (reset),
        .en_code   (en_code),
        .CODE_IN   (CODE_IN),
        .DATA_OUT  (DATA_OUT),
        .SYN_OUT   (SYN_OUT),
        .CRC_Err   (CRC_Err),
        .Chk_Valid (Chk_Valid),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        logic [6:0]  syn;
        int          cap;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_vld = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Polynomial long division by x^7+x^3+1 (bit pattern 1000_1001).
    function automatic logic [6:0] mod_g(input logic [29:0] v_in);
        logic [29:0] v;
        v = v_in;
        for (int i = 29; i >= 7; i--)
            if (v[i]) v[i-:8] = v[i-:8] ^ 8'h89;
        return v[6:0];
    endfunction

    // Scoreboard consumer.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (Chk_Valid) begin
            chk("valid_pulse_width", prev_vld, 0);
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("syn",     SYN_OUT,     e.syn);
                chk("err",     CRC_Err,     e.syn != 0);
                chk("data",    DATA_OUT,    e.data);
                chk("latency", cyc - e.cap, 23);
            end
        end
        prev_vld <= Chk_Valid;
    end

    // Called at #1 after a rising edge while the DUT is idle.
    task automatic send(input logic [22:0] cw, input bit push);
        exp_t e;
        en_code = 1'b1;
        CODE_IN = cw;
        if (push) begin
            e.data = cw[22:7];
            e.syn  = mod_g({cw, 7'b0});
            e.cap  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge CLK); #1;
        en_code = 1'b0;
        CODE_IN = 23'($urandom);  // must not matter after capture
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && Busy; i++) begin
            @(posedge CLK); #1;
        end
        chk("idle_timeout", Busy, 0);
    endtask

    initial begin
        logic [15:0] d;
        logic [6:0]  c;
        logic [22:0] cw;

        reset   = 1'b1;
        en_code = 1'b0;
        CODE_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy",  Busy,      0);
        chk("rst_valid", Chk_Valid, 0);
        chk("rst_data",  DATA_OUT,  0);
        chk("rst_syn",   SYN_OUT,   0);
        chk("rst_err",   CRC_Err,   0);
        reset = 1'b0;
        @(posedge CLK); #1;

        // Directed words.
        send(23'h000089, 1); chk("busy_after_cap", Busy, 1); wait_idle();
        send(23'h000088, 1); wait_idle();
        send(23'h000000, 1); wait_idle();

        // en_code during SHIFT is ignored; then back-to-back accept.
        send(23'h000089, 1);
        repeat (4) begin @(posedge CLK); #1; end
        chk("busy_mid_shift", Busy, 1);
        en_code = 1'b1;
        CODE_IN = 23'h7fffff;
        @(posedge CLK); #1;
        en_code = 1'b0;
        for (int i = 0; i < 40 && !Chk_Valid; i++) begin
            @(posedge CLK); #1;
        end
        chk("b2b_valid_seen", Chk_Valid, 1);
        send(23'h000088, 1);
        chk("b2b_busy", Busy, 1);
        wait_idle();

        // Reset in the middle of a word aborts it.
        send(23'h012345, 1);
        repeat (9) begin @(posedge CLK); #1; end
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        sb.delete();
        chk("abort_busy",  Busy,      0);
        chk("abort_valid", Chk_Valid, 0);
        chk("abort_data",  DATA_OUT,  0);
        chk("abort_syn",   SYN_OUT,   0);
        chk("abort_err",   CRC_Err,   0);
        repeat (30) @(posedge CLK);
        #1;

        // Encoder loopback, with every fourth word corrupted by one bit.
        for (int i = 0; i < 1000; i++) begin
            d  = 16'($urandom);
            c  = mod_g({7'b0, d, 7'b0});
            cw = {d, c};
            if (i % 4 == 3) cw = cw ^ (23'd1 << $urandom_range(22, 0));
            send(cw, 1);
            wait_idle();
        end

        repeat (5) @(posedge CLK);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
